// File: rtl/ahb_to_apb_bridge_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
// Holds the bridge state enum, AHB encodings and the size/strobe helpers.
// No ports; imported by the bridge top and the slot decoder.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Only byte/half/word are reachable on a 32-bit APB; halfwords and words
  // must be naturally aligned.
  function automatic logic size_ok(input logic [2:0] hsize, input logic [1:0] lsb);
    case (hsize)
      HSIZE_BYTE: size_ok = 1'b1;
      HSIZE_HALF: size_ok = ~lsb[0];
      HSIZE_WORD: size_ok = (lsb == 2'b00);
      default:    size_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] wr_strb(input logic [2:0] hsize, input logic [1:0] lsb);
    case (hsize)
      HSIZE_BYTE: wr_strb = 4'b0001 << lsb;
      HSIZE_HALF: wr_strb = 4'b0011 << {lsb[1], 1'b0};
      HSIZE_WORD: wr_strb = 4'b1111;
      default:    wr_strb = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb_to_apb_bridge_if.sv
// Bus bundle between the AHB-Lite interconnect, the bridge and the APB slots.
// slave modport: the bridge view (AHB slave inputs, APB master outputs).
// master modport: the surrounding fabric view (drives AHB, models APB slots).
interface ahb_to_apb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                             hsel;
  logic [ADDR_WIDTH-1:0]            haddr;
  logic [1:0]                       htrans;
  logic                             hwrite;
  logic [2:0]                       hsize;
  logic [DATA_WIDTH-1:0]            hwdata;
  logic                             hready;
  logic                             hreadyout;
  logic                             hresp;
  logic [DATA_WIDTH-1:0]            hrdata;
  logic [ADDR_WIDTH-1:0]            paddr;
  logic [NUM_SLAVES-1:0]            psel;
  logic                             penable;
  logic                             pwrite;
  logic [DATA_WIDTH-1:0]            pwdata;
  logic [3:0]                       pstrb;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
  logic [NUM_SLAVES-1:0]            pready;
  logic [NUM_SLAVES-1:0]            pslverr;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ahb_to_apb_bridge_decoder.sv
// Combinational APB slot decoder: maps an AHB address onto one of NUM_SLAVES slots.
// In: haddr. Out: slot_idx (binary), hit (address inside the window), slot_sel (one-hot, 0 on miss).
// Window is BASE_ADDR .. BASE_ADDR + NUM_SLAVES * 2**SLOT_LOG2 - 1.
module apb_slot_decoder
  import ahb_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_SLAVES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int                    SLOT_LOG2  = 12,
  parameter int                    IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] haddr,
  output logic [IDX_W-1:0]      slot_idx,
  output logic                  hit,
  output logic [NUM_SLAVES-1:0] slot_sel
);

  // One extra bit so the upper bound cannot wrap at the top of the map.
  localparam int                  AW1  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] SPAN = AW1'(NUM_SLAVES) << SLOT_LOG2;
  localparam logic [ADDR_WIDTH:0] HI   = LO + SPAN;

  always_comb begin
    hit      = ({1'b0, haddr} >= LO) && ({1'b0, haddr} < HI);
    slot_idx = haddr[SLOT_LOG2 +: IDX_W];
    slot_sel = '0;
    if (hit) slot_sel[slot_idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS per AHB single transfer.
// Ports: pclk, presetn (async active-low), bus (slave modport: AHB side in, APB side out).
// Latency: read 3, write 4 cycles address phase to hreadyout, plus APB waits; errors are 2-cycle.
module ahb_to_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SLAVES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000,
  parameter int                    SLOT_LOG2  = 12,
  parameter int                    TIMEOUT    = 0
) (
  input logic                pclk,
  input logic                presetn,
  ahb_to_apb_bridge_if.slave bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                state_q, state_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;   // select held across LATCH for writes
  logic [CNT_W-1:0]      cnt_q, cnt_d;   // ACCESS cycles already spent waiting

  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  accept;
  logic                  xfer_ok;

  apb_slot_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_LOG2  (SLOT_LOG2),
    .IDX_W      (IDX_W)
  ) u_dec (
    .haddr    (bus.haddr),
    .slot_idx (dec_idx),
    .hit      (dec_hit),
    .slot_sel (dec_sel)
  );

  always_comb begin
    accept  = bus.hsel && bus.htrans[1] && bus.hready;
    xfer_ok = dec_hit && size_ok(bus.hsize, bus.haddr[1:0]);

    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    idx_d       = idx_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;

    case (state_q)
      // ERR2 is the second error cycle with hreadyout high, so a pipelined
      // address phase can land here and must be taken exactly like in IDLE.
      ST_IDLE, ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        if (accept) begin
          hreadyout_d = 1'b0;
          if (!xfer_ok) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else begin
            paddr_d  = bus.haddr;
            pwrite_d = bus.hwrite;
            pstrb_d  = bus.hwrite ? wr_strb(bus.hsize, bus.haddr[1:0]) : 4'b0000;
            idx_d    = dec_idx;
            sel_d    = dec_sel;
            if (bus.hwrite) begin
              state_d = ST_LATCH;
            end else begin
              state_d = ST_SETUP;
              psel_d  = dec_sel;
            end
          end
        end
      end
      // hwdata belongs to the data phase, one cycle after the address.
      ST_LATCH: begin
        pwdata_d = bus.hwdata;
        psel_d   = sel_q;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.pready[idx_q]) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (bus.pslverr[idx_q]) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            if (!pwrite_q) hrdata_d = bus.prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
          end
        end else if (TIMEOUT != 0 && int'(cnt_q) == TIMEOUT - 1) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_ERR1;
          hresp_d   = HRESP_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        hresp_d     = HRESP_ERROR;
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      idx_q       <= idx_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = hresp_q;
  assign bus.hrdata    = hrdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Self-checking bench for ahb_to_apb_bridge: directed cases plus randomized transfers
// scored against a transaction-level model of address map, legality, strobes and timing.
module tb_ahb_to_apb_bridge;
  import ahb_apb_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam int          SL   = 12;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  ahb_to_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();
  assign bus.hready = bus.hreadyout;

  ahb_to_apb_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .BASE_ADDR  (BASE),
    .SLOT_LOG2  (SL),
    .TIMEOUT    (0)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_hrdata = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit m_hit(input logic [31:0] a);
    longint la = {32'h0, a};
    longint lb = {32'h0, BASE};
    return (la >= lb) && (la < lb + NS * (1 << SL));
  endfunction

  function automatic int m_slot(input logic [31:0] a);
    return int'((a - BASE) / (32'd1 << SL));
  endfunction

  function automatic bit m_legal(input logic [2:0] size, input logic [31:0] a);
    if (size > 2) return 1'b0;
    return (a % (32'd1 << size)) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input bit wr, input logic [2:0] size, input logic [31:0] a);
    if (!wr) return 4'h0;
    case (size)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  // Caller is at a negedge; the address phase is driven right away so that
  // back-to-back calls present the next transfer in the completing cycle.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int waits, input bit slverr,
                      input logic [31:0] rdata);
    bit          bad      = !(m_hit(addr) && m_legal(size, addr));
    int          es       = bad ? 0 : m_slot(addr);
    int          exp_lat  = bad ? 2 : ((wr ? 4 : 3) + waits + (slverr ? 1 : 0));
    bit          exp_err  = bad || slverr;
    int          c = 0, lat = -1, pen = 0, acc = 0, resp_early = 0;
    bit          seen = 1'b0, end_resp = 1'b0, f_pen = 1'b0, f_pwrite = 1'b0;
    logic [3:0]  f_psel = '0, f_pstrb = '0;
    logic [31:0] f_paddr = '0, f_pwdata = '0;

    bus.hsel   = 1'b1;
    bus.htrans = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.hsize  = size;
    for (int s = 0; s < NS; s++) bus.prdata[s*32 +: 32] = $urandom;
    bus.prdata[es*32 +: 32] = rdata;

    while (lat < 0 && c < 60) begin
      @(negedge pclk);
      c++;
      if (c == 1) begin
        bus.hsel   = 1'($urandom_range(0, 1));
        bus.htrans = 2'($urandom_range(0, 1));
        bus.haddr  = $urandom;
        bus.hwdata = wdata;
      end else begin
        bus.hwdata = $urandom;
      end
      if (bus.psel != 0 && !seen) begin
        seen     = 1'b1;
        f_psel   = bus.psel;
        f_paddr  = bus.paddr;
        f_pstrb  = bus.pstrb;
        f_pwrite = bus.pwrite;
        f_pwdata = bus.pwdata;
        f_pen    = bus.penable;
      end
      if (bus.penable) pen++;
      if (bus.hresp && !bus.hreadyout) resp_early++;
      if (bus.hreadyout) begin
        lat      = c;
        end_resp = bus.hresp;
      end
      // APB slots: unselected slots babble; the target slot follows the plan.
      for (int s = 0; s < NS; s++) begin
        bus.pready[s]  = 1'($urandom_range(0, 1));
        bus.pslverr[s] = 1'($urandom_range(0, 1));
      end
      if (!bad && lat < 0 && bus.penable) begin
        bus.pready[es]  = (acc == waits);
        bus.pslverr[es] = slverr && (acc == waits);
        acc++;
      end
    end

    check_eq("latency", lat, exp_lat);
    check_eq("end_hresp", end_resp, exp_err);
    check_eq("err_first_cycle", resp_early, exp_err ? 1 : 0);
    check_eq("psel", f_psel, bad ? 4'h0 : 4'(1 << es));
    if (!bad) begin
      check_eq("paddr", f_paddr, addr);
      check_eq("pwrite", f_pwrite, wr);
      check_eq("pstrb", f_pstrb, m_strb(wr, size, addr));
      check_eq("setup_penable", f_pen, 1'b0);
      check_eq("penable_cycles", pen, waits + 1);
      if (wr) check_eq("pwdata", f_pwdata, wdata);
    end
    if (!wr && !exp_err) exp_hrdata = rdata;
    check_eq("hrdata", bus.hrdata, exp_hrdata);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.hsel   = 1'($urandom_range(0, 1));
      bus.htrans = $urandom_range(0, 1) ? HTRANS_BUSY : HTRANS_IDLE;
      bus.haddr  = BASE + $urandom_range(0, 32'h3FFF);
      bus.hwrite = 1'($urandom_range(0, 1));
      @(negedge pclk);
      check_eq("gap_hreadyout", bus.hreadyout, 1'b1);
      check_eq("gap_hresp", bus.hresp, 1'b0);
      check_eq("gap_psel", bus.psel, 4'h0);
    end
  endtask

  task automatic reset_mid_access();
    bus.hsel   = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.haddr  = BASE + 32'h1004;
    bus.hwrite = 1'b0;
    bus.hsize  = HSIZE_WORD;
    bus.pready = '0;
    for (int i = 0; i < 10 && !bus.penable; i++) begin
      @(negedge pclk);
      bus.hsel   = 1'b0;
      bus.htrans = HTRANS_IDLE;
    end
    check_eq("rst_reached_access", bus.penable, 1'b1);
    #2 presetn = 1'b0;
    #1;
    check_eq("rst_psel", bus.psel, 4'h0);
    check_eq("rst_penable", bus.penable, 1'b0);
    check_eq("rst_hresp", bus.hresp, 1'b0);
    check_eq("rst_hreadyout", bus.hreadyout, 1'b1);
    check_eq("rst_hrdata", bus.hrdata, 32'h0);
    exp_hrdata = '0;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    bus.hsel    = 1'b0;
    bus.htrans  = HTRANS_IDLE;
    bus.haddr   = '0;
    bus.hwrite  = 1'b0;
    bus.hsize   = HSIZE_WORD;
    bus.hwdata  = '0;
    bus.prdata  = '0;
    bus.pready  = '0;
    bus.pslverr = '0;

    @(negedge pclk);
    @(negedge pclk);
    check_eq("reset_hreadyout", bus.hreadyout, 1'b1);
    check_eq("reset_hresp", bus.hresp, 1'b0);
    check_eq("reset_hrdata", bus.hrdata, 32'h0);
    check_eq("reset_psel", bus.psel, 4'h0);
    check_eq("reset_penable", bus.penable, 1'b0);
    check_eq("reset_paddr", bus.paddr, 32'h0);
    check_eq("reset_pwrite", bus.pwrite, 1'b0);
    check_eq("reset_pwdata", bus.pwdata, 32'h0);
    check_eq("reset_pstrb", bus.pstrb, 4'h0);
    presetn = 1'b1;
    @(negedge pclk);

    xfer(32'h4000_1008, 1'b1, HSIZE_WORD, 32'h0000_0100, 0, 1'b0, 32'h0);
    xfer(32'h4000_1004, 1'b0, HSIZE_WORD, 32'h0,         2, 1'b0, 32'h0000_002A);
    xfer(32'h4000_1003, 1'b1, HSIZE_BYTE, 32'hAB00_0000, 0, 1'b0, 32'h0);
    xfer(32'h4000_1002, 1'b1, HSIZE_HALF, 32'h1234_0000, 1, 1'b0, 32'h0);
    xfer(32'h4000_1001, 1'b1, HSIZE_HALF, 32'h5555_5555, 0, 1'b0, 32'h0);
    xfer(32'h4000_4000, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h1111_1111);
    xfer(32'h4000_2010, 1'b0, HSIZE_WORD, 32'h0,         1, 1'b1, 32'hDEAD_BEEF);
    xfer(32'h4000_2014, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h0000_0055);
    xfer(32'h4000_0006, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h0);
    xfer(32'h3FFF_FFFC, 1'b1, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h0);
    xfer(32'h4000_3FFC, 1'b0, 3'd3,       32'h0,         0, 1'b0, 32'h0);
    idle_gap(3);
    reset_mid_access();
    xfer(32'h4000_3000, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 0, 1'b0, 32'h0);
    xfer(32'h4000_30FC, 1'b0, HSIZE_WORD, 32'h0,         0, 1'b0, 32'h7777_0001);

    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'($urandom_range(1, 64));
        1:       a = BASE + 32'h4000 + 32'($urandom_range(0, 32'h3FFF));
        2:       a = $urandom;
        default: a = BASE + 32'($urandom_range(0, 32'h3FFF));
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, $urandom_range(0, 3),
           $urandom_range(0, 5) == 0, $urandom);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 2));
    end
    idle_gap(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
